// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
//
// Purpose: FSM state encoding, register-index width and default memory wait
// budget used by pipeline_ctrl and hazard_detect.
// Ports: none (package).

package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int RegIdxW    = 5;
  localparam int DefMaxWait = 16;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
//
// Purpose: flags when the instruction in ID reads the destination of a load
// currently held in ID/EX. Register x0 never creates a dependency.
// Ports:
//   id_rs1n, id_rs2n  in  source register indices of the ID instruction
//   idex_rdn          in  destination index held in ID/EX
//   idex_mem_read     in  ID/EX instruction is a load
//   load_use          out hazard detected

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [RegIdxW-1:0] id_rs1n,
  input  logic [RegIdxW-1:0] id_rs2n,
  input  logic [RegIdxW-1:0] idex_rdn,
  input  logic               idex_mem_read,
  output logic               load_use
);

  assign load_use = idex_mem_read && (idex_rdn != '0) &&
                    ((idex_rdn == id_rs1n) || (idex_rdn == id_rs2n));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard and sequencing controller for the 5-stage pipeline
//
// Purpose: per-stage enables/flushes, load-use stall, branch squash, data
// memory request/ready handshake with wait timeout, saturating stall counter.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   id_rs1n, id_rs2n, idex_rdn        register indices for load-use detection
//   idex_mem_read                     ID/EX holds a load
//   exmem_branch_taken                EX/MEM resolved a taken branch/jump
//   exmem_mem_op                      EX/MEM holds a load or store
//   dmem_ready                        data memory completes this cycle
//   pc_en .. memwb_en                 stage load enables
//   ifid_flush .. exmem_flush         stage clears at next edge
//   memwb_bubble                      MEM/WB loads a bubble
//   dmem_req                          data memory request valid
//   mem_err                           one-cycle pulse after a timeout cycle
//   stall_count                       saturating count of pc_en=0 cycles

module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MaxWait  = DefMaxWait,
  parameter int CntWidth = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [RegIdxW-1:0]  id_rs1n,
  input  logic [RegIdxW-1:0]  id_rs2n,
  input  logic [RegIdxW-1:0]  idex_rdn,
  input  logic                idex_mem_read,
  input  logic                exmem_branch_taken,
  input  logic                exmem_mem_op,
  input  logic                dmem_ready,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                exmem_flush,
  output logic                memwb_bubble,
  output logic                dmem_req,
  output logic                mem_err,
  output logic [CntWidth-1:0] stall_count
);

  localparam logic [7:0] WaitLast = 8'(MaxWait - 1);

  state_e                state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  mem_err_q;
  logic [CntWidth-1:0]   stall_count_q;

  logic load_use;
  logic req_raw;
  logic timeout;
  logic mem_stall;

  hazard_detect u_hazard_detect (
    .id_rs1n       (id_rs1n),
    .id_rs2n       (id_rs2n),
    .idex_rdn      (idex_rdn),
    .idex_mem_read (idex_mem_read),
    .load_use      (load_use)
  );

  // A timed-out access is treated as complete, so it must not stall.
  always_comb begin
    req_raw   = (state_q == MEM_WAIT) ? 1'b1 : exmem_mem_op;
    timeout   = (state_q == MEM_WAIT) && (wait_cnt_q == WaitLast) && !dmem_ready;
    mem_stall = req_raw && !dmem_ready && !timeout;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        // Zero-wait accesses complete in RUN without a state change.
        if (exmem_mem_op && !dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || timeout) begin
          state_d = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
    endcase
  end

  // Priority mux: memory stall freezes everything (deferring any branch or
  // load-use), then branch squash, then load-use bubble.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = req_raw;
    if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (exmem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
    if (!rstn) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      dmem_req     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= timeout;
      if (!pc_en && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CntWidth'(1);
      end
    end
  end

  assign mem_err     = mem_err_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage core pipeline.
- Generates per-stage enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards.
- Squashes younger instructions on a taken branch resolved in the EX/MEM stage.
- Runs the data-memory request/ready handshake, with a wait timeout and a saturating stall counter.

Parameters:
- MaxWait, 16, memory wait cycles allowed before timeout (range 2..255).
- CntWidth, 32, width of the stall_count performance counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- id_rs1n  in  5  rs1 index of the instruction in ID
- id_rs2n  in  5  rs2 index of the instruction in ID
- idex_rdn  in  5  rd index held in ID/EX
- idex_mem_read  in  1  ID/EX instruction is a load
- exmem_branch_taken  in  1  EX/MEM instruction is a taken branch or jump
- exmem_mem_op  in  1  EX/MEM instruction is a load or store
- dmem_ready  in  1  data memory completes the current request this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- idex_en  out  1  ID/EX load enable
- exmem_en  out  1  EX/MEM load enable
- memwb_en  out  1  MEM/WB load enable
- ifid_flush  out  1  clear IF/ID at the next edge
- idex_flush  out  1  clear ID/EX at the next edge
- exmem_flush  out  1  clear EX/MEM at the next edge
- memwb_bubble  out  1  load a bubble into MEM/WB instead of MEM results
- dmem_req  out  1  data memory request valid
- mem_err  out  1  one-cycle registered pulse on memory timeout
- stall_count  out  CntWidth  saturating count of cycles with pc_en=0

Behaviour:
FSM and registers
- FSM states: RUN, MEM_WAIT.
- Registers: state, wait_cnt [7:0], mem_err, stall_count.
- Reset (rstn low, asynchronous): state=RUN, wait_cnt=0, mem_err=0, stall_count=0.
- While rstn is low, all combinational outputs are forced to 0: enables, flushes, memwb_bubble, dmem_req.

dmem_req
- dmem_req = exmem_mem_op in RUN.
- dmem_req = 1 in MEM_WAIT.

mem_stall
- timeout = (state==MEM_WAIT) && (wait_cnt==MaxWait-1) && !dmem_ready.
- mem_stall = dmem_req && !dmem_ready && !timeout.

Transitions
- RUN -> MEM_WAIT when exmem_mem_op && !dmem_ready; wait_cnt <= 0.
- MEM_WAIT -> RUN on dmem_ready, or on timeout.
  - On timeout: mem_err <= 1 for exactly one cycle, and the access is treated as complete (pipeline advances that cycle).
- Otherwise MEM_WAIT holds and wait_cnt increments.
- Zero-wait access (dmem_ready in the same RUN cycle as the request) causes no stall and no state change.

Priority, highest first
1. mem_stall
   - pc_en = ifid_en = idex_en = exmem_en = 0.
   - memwb_en = 1, memwb_bubble = 1.
   - All flushes = 0. A coincident branch or load-use is deferred; inputs are held by the frozen registers.
2. Branch flush (exmem_branch_taken)
   - ifid_flush = idex_flush = exmem_flush = 1.
   - All enables = 1; the PC takes the redirect target.
   - Load-use detection is suppressed.
3. Load-use stall
   - Condition: idex_mem_read && idex_rdn!=0 && (idex_rdn==id_rs1n || idex_rdn==id_rs2n).
   - pc_en = ifid_en = 0; idex_flush = 1 (bubble).
   - idex_en = exmem_en = memwb_en = 1.
   - Exactly one stall cycle, since the load moves on to EX/MEM.
4. Default
   - All enables = 1, all flushes = 0, memwb_bubble = 0.

stall_count
- Increments on every cycle with pc_en=0 and rstn high.
- Saturates at all-ones; no wrap.

Latency
- Control outputs are combinational from state and inputs, with zero latency.
- mem_err is registered and asserts the cycle after the timeout cycle.

Decomposition
- Package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT}.
  - Register-index width constant RegIdxW=5.
  - Default MaxWait constant.
- Sub-module hazard_detect: purely combinational load-use comparator (id_rs1n, id_rs2n, idex_rdn, idex_mem_read -> load_use). The main block holds the FSM, counters and priority mux.

Test Plan
- Load-use: idex_mem_read=1, idex_rdn=5, id_rs1n=5 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_count 0->1. Same stimulus with idex_rdn=0 -> no stall.
- Branch with pending load-use: exmem_branch_taken=1 plus load-use condition -> ifid_flush=idex_flush=exmem_flush=1, pc_en=1, no stall; stall_count unchanged.
- Memory wait: exmem_mem_op=1, dmem_ready low 3 cycles then high -> dmem_req high 4 cycles, stage enables 0 for 3 cycles, memwb_bubble=1 for 3 cycles, state returns to RUN, stall_count=3.
- Timeout: MaxWait=4, dmem_ready never asserted -> enables released on the 5th request cycle (wait_cnt=3 in MEM_WAIT), mem_err high the following cycle only, state=RUN.
- Memory stall plus branch: mem stall active while exmem_branch_taken=1 -> no flushes until dmem_ready, then flush asserted.
- Reset mid-operation: rstn pulled low while in MEM_WAIT with wait_cnt=2 -> state=RUN, wait_cnt=0, stall_count=0, all outputs 0 immediately (asynchronous), normal operation on release.
